gcd_job_sequencer: RTL and testbench

Upstream feeder for the GCD custom-instruction engine (start/done handshake, dataa/datab/result).
- Accepts operand pairs over a valid/ready stream into a small FIFO.
- Dispatches pairs one at a time: one-cycle start pulse, operands held stable, wait for done.
- Returns each result on a valid/ready output stream.
- Zero-operand jobs are resolved locally and never reach the engine.

---
 rtl/gcd_job_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_sequencer.sv
// Operand-pair FIFO and dispatcher for the GCD custom-instruction engine.
// Optional WAIT-state timeout is built in when GCD_SEQ_TIMEOUT_EN is defined.
module gcd_job_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_bypass,
  output logic             out_error,
  output logic             ci_clk_en,
  output logic             ci_start,
  output logic [WIDTH-1:0] ci_dataa,
  output logic [WIDTH-1:0] ci_datab,
  input  logic             ci_done,
  input  logic [WIDTH-1:0] ci_result,
  output logic             busy,
  output logic [15:0]      jobs_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("gcd_job_sequencer: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop, empty;
  logic [WIDTH-1:0] head_a, head_b;
  logic [WIDTH-1:0] dataa_q, dataa_d, datab_q, datab_d, result_q, result_d;
  logic             bypass_q, bypass_d, error_q, error_d;
  logic [15:0]      jobs_q, jobs_d;
  logic             timeout_hit;

  assign in_ready = (count_q != FullCount);
  assign empty    = (count_q == '0);
  assign push     = in_valid & in_ready;
  assign head_a   = fifo_a[rd_ptr_q];
  assign head_b   = fifo_b[rd_ptr_q];

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr_q] <= in_a;
      fifo_b[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt_q;

  // Holds the number of cycles elapsed since LAUNCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
    end else if (state_q == StLaunch || state_q == StWait) begin
      tcnt_q <= tcnt_q + TW'(1);
    end else begin
      tcnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q == StWait) && (tcnt_q == TimeoutLast);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    dataa_d  = dataa_q;
    datab_d  = datab_q;
    result_d = result_q;
    bypass_d = bypass_q;
    error_d  = error_q;
    jobs_d   = jobs_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          dataa_d = head_a;
          datab_d = head_b;
          if (head_a == '0 || head_b == '0) begin
            result_d = head_a | head_b;
            bypass_d = 1'b1;
            error_d  = 1'b0;
            state_d  = StHold;
          end else begin
            state_d = StLaunch;
          end
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (ci_done) begin
          result_d = ci_result;
          bypass_d = 1'b0;
          error_d  = 1'b0;
          state_d  = StHold;
        end else if (timeout_hit) begin
          result_d = '0;
          bypass_d = 1'b0;
          error_d  = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          jobs_d  = jobs_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      dataa_q  <= '0;
      datab_q  <= '0;
      result_q <= '0;
      bypass_q <= 1'b0;
      error_q  <= 1'b0;
      jobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      dataa_q  <= dataa_d;
      datab_q  <= datab_d;
      result_q <= result_d;
      bypass_q <= bypass_d;
      error_q  <= error_d;
      jobs_q   <= jobs_d;
    end
  end

  assign ci_clk_en  = rst;
  assign ci_start   = (state_q == StLaunch);
  assign ci_dataa   = dataa_q;
  assign ci_datab   = datab_q;
  assign out_valid  = (state_q == StHold);
  assign out_result = result_q;
  assign out_bypass = bypass_q;
  assign out_error  = error_q;
  assign busy       = (state_q != StIdle) || !empty;
  assign jobs_done  = jobs_q;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Scoreboard bench for gcd_job_sequencer with a behavioural GCD engine model.
module tb_gcd_job_sequencer;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, out_bypass, out_error;
  logic [W-1:0]  in_a, in_b, out_result, ci_dataa, ci_datab, ci_result;
  logic          ci_clk_en, ci_start, ci_done, busy;
  logic [15:0]   jobs_done;

  gcd_job_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_bypass(out_bypass), .out_error(out_error), .ci_clk_en(ci_clk_en),
    .ci_start(ci_start), .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_done(ci_done),
    .ci_result(ci_result), .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         byp;
    logic         err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   starts = 0;
  int   eng_jobs = 0;
  int   tb_jobs = 0;
  bit   mute = 1'b0;
  bit   expect_timeout = 1'b0;
  bit   rnd_ready = 1'b0;

  function automatic logic [W-1:0] ref_gcd(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(string name);
    checks++;
    $display("FAIL %s: got no event expected event", name);
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  initial begin
    exp_t e;
    logic [W-1:0] g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sbq.delete();
        tb_jobs = 0;
      end else begin
        if (in_valid && in_ready) begin
          e.byp = (in_a == 0) || (in_b == 0);
          g = ref_gcd(in_a, in_b);
          e.err = !e.byp && expect_timeout;
          e.res = e.err ? '0 : g;
          if (!e.byp) eng_jobs++;
          sbq.push_back(e);
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            fail_now("unexpected_result");
          end else begin
            e = sbq.pop_front();
            chk("out_result", out_result, e.res);
            chk("out_bypass", W'(out_bypass), W'(e.byp));
            chk("out_error", W'(out_error), W'(e.err));
          end
          chk("jobs_done", W'(jobs_done), W'(tb_jobs[15:0]));
          tb_jobs++;
        end
      end
    end
  end

  // Engine model: answers each start after a random delay, watches operand stability.
  initial begin
    bit           active;
    int           wait_cnt;
    logic [W-1:0] cap_a, cap_b;
    bit           moved;
    active  = 1'b0;
    ci_done = 1'b0;
    ci_result = '0;
    forever begin
      @(posedge clk);
      #1;
      ci_done = 1'b0;
      if (!rst) begin
        active = 1'b0;
      end else begin
        if (active) begin
          if (ci_dataa != cap_a || ci_datab != cap_b) moved = 1'b1;
          if (wait_cnt == 0) begin
            chk("ci_operands_stable", W'(moved), '0);
            ci_done   = 1'b1;
            ci_result = ref_gcd(cap_a, cap_b);
            active    = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
        if (ci_start) begin
          starts++;
          if (!mute) begin
            cap_a    = ci_dataa;
            cap_b    = ci_datab;
            moved    = 1'b0;
            active   = 1'b1;
            wait_cnt = $urandom_range(0, 5);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b);
    bit acc;
    acc = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) fail_now("accept_timeout");
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = !busy && !out_valid;
      if (!done) tick();
    end
    if (!done) fail_now("drain_timeout");
    else tick();
  endtask

  task automatic out_latency(output int cyc);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
    end
  endtask

  initial begin
    int s0, cyc, acc;
    logic [W-1:0] g, a, b;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_ci_clk_en", W'(ci_clk_en), 0);
    chk("rst_ci_start", W'(ci_start), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_jobs_done", W'(jobs_done), 0);
    chk("rst_out_result", out_result, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("ci_clk_en_run", W'(ci_clk_en), 1);

    s0 = starts;
    send(91, 21);
    wait_idle();
    chk("single_job_starts", W'(starts - s0), 1);
    chk("single_job_count", W'(jobs_done), 1);

    send(2147483647, 524287);
    send(1000000000, 1);
    send(2, 1023);
    wait_idle();

    s0 = starts;
    send(0, 12);
    out_latency(cyc);
    chk("bypass_latency_a", W'(cyc), 2);
    wait_idle();
    send(0, 0);
    out_latency(cyc);
    chk("bypass_latency_b", W'(cyc), 2);
    wait_idle();
    chk("bypass_no_start", W'(starts - s0), 0);

    // Stalled consumer: one job parks in HOLD, DEPTH more fill the FIFO.
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    in_a = $urandom_range(1, 1000);
    in_b = $urandom_range(0, 1000);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc++;
        tick();
        in_a = $urandom_range(1, 1000);
        in_b = $urandom_range(0, 1000);
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_accepted", W'(acc), 5);
    chk("stall_in_ready", W'(in_ready), 0);
    tick();
    out_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("drain_in_ready", W'(in_ready), 1);
    tick();

    rnd_ready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      g = $urandom_range(1, 1000);
      a = g * $urandom_range(1, 5000);
      b = g * $urandom_range(1, 5000);
      if ($urandom_range(0, 7) == 0) a = '0;
      if ($urandom_range(0, 7) == 0) b = '0;
      send(a, b);
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Reset while the engine is being waited on.
    mute = 1'b1;
    s0 = starts;
    send(5, 3);
    for (int i = 0; i < 20 && starts == s0; i++) tick();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("wait_rst_out_valid", W'(out_valid), 0);
    chk("wait_rst_busy", W'(busy), 0);
    chk("wait_rst_in_ready", W'(in_ready), 1);
    chk("wait_rst_ci_clk_en", W'(ci_clk_en), 0);
    chk("wait_rst_ci_dataa", ci_dataa, 0);
    chk("wait_rst_jobs_done", W'(jobs_done), 0);
    tick();
    rst = 1'b1;
    mute = 1'b0;
    tick();
    send(12, 18);
    wait_idle();
    chk("post_rst_jobs_done", W'(jobs_done), 1);

`ifdef GCD_SEQ_TIMEOUT_EN
    mute = 1'b1;
    expect_timeout = 1'b1;
    send(9, 6);
    for (int i = 0; i < 20 && !ci_start; i++) @(negedge clk);
    out_latency(cyc);
    chk("timeout_latency", W'(cyc), TO);
    wait_idle();
    mute = 1'b0;
    expect_timeout = 1'b0;
`endif

    chk("engine_starts", W'(starts), W'(eng_jobs));
    chk("scoreboard_empty", W'(sbq.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
